// File: rtl/fpu_addsub_arbiter.sv
// fpu_addsub_arbiter: round-robin sharing of one pipelined FP add/sub unit.
// A tag pipe matched to the FPU latency steers each result to its requester.
module fpu_addsub_arbiter #(
  parameter int N_REQ     = 4,
  parameter int SIZE_DATA = 32,
  parameter int LATENCY   = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ*SIZE_DATA-1:0] i_req_a,
  input  logic [N_REQ*SIZE_DATA-1:0] i_req_b,
  input  logic [N_REQ-1:0]           i_req_op,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic                       o_fpu_valid,
  output logic [SIZE_DATA-1:0]       o_fpu_a,
  output logic [SIZE_DATA-1:0]       o_fpu_b,
  output logic                       o_fpu_op,
  input  logic [SIZE_DATA-1:0]       i_fpu_result,
  output logic [N_REQ-1:0]           o_rsp_valid,
  output logic [SIZE_DATA-1:0]       o_rsp_data,
  output logic                       o_busy
);

  localparam int TW = $clog2(N_REQ);

  typedef struct packed {
    logic          vld;
    logic [TW-1:0] tag;
  } tag_t;

  logic [TW-1:0]        ptr;
  logic [TW-1:0]        idx;
  logic [TW-1:0]        gnt_idx;
  logic [TW-1:0]        iss_tag;
  logic [N_REQ-1:0]     gnt;
  logic                 gnt_any;
  logic [SIZE_DATA-1:0] sel_a;
  logic [SIZE_DATA-1:0] sel_b;
  logic                 sel_op;
  tag_t                 pipe [LATENCY];
  tag_t                 tail;

  function automatic logic [TW-1:0] wrap_idx(
    input logic [TW-1:0] base,
    input int            off
  );
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return TW'(s);
  endfunction

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = wrap_idx(ptr, i);
      if (!gnt_any && i_req_valid[idx]) begin
        gnt_any  = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
    if (i_rst) begin
      gnt     = '0;
      gnt_any = 1'b0;
    end
  end

  assign o_req_ready = gnt;

  always_comb begin
    sel_a  = i_req_a[gnt_idx*SIZE_DATA +: SIZE_DATA];
    sel_b  = i_req_b[gnt_idx*SIZE_DATA +: SIZE_DATA];
    sel_op = i_req_op[gnt_idx];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr         <= '0;
      iss_tag     <= '0;
      o_fpu_valid <= 1'b0;
      o_fpu_a     <= '0;
      o_fpu_b     <= '0;
      o_fpu_op    <= 1'b0;
    end else begin
      o_fpu_valid <= gnt_any;
      if (gnt_any) begin
        ptr      <= wrap_idx(gnt_idx, 1);
        iss_tag  <= gnt_idx;
        o_fpu_a  <= sel_a;
        o_fpu_b  <= sel_b;
        o_fpu_op <= sel_op;
      end
    end
  end

  // Tail stage lines up with i_fpu_result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0].vld <= o_fpu_valid;
      pipe[0].tag <= iss_tag;
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tail = pipe[LATENCY-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp_valid <= '0;
      o_rsp_data  <= '0;
    end else begin
      o_rsp_valid <= '0;
      if (tail.vld) begin
        o_rsp_valid <= N_REQ'(1) << tail.tag;
        o_rsp_data  <= i_fpu_result;
      end
    end
  end

  always_comb begin
    o_busy = o_fpu_valid;
    for (int i = 0; i < LATENCY; i++) begin
      o_busy = o_busy | pipe[i].vld;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// tb_fpu_addsub_arbiter: scoreboard bench with a pipelined FPU model and
// a round-robin reference; monitor checks issue, busy and responses.
module tb_fpu_addsub_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 3;
  localparam int MAXC = 8192;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_op;
  logic [N-1:0]   req_ready;
  logic           fpu_valid;
  logic [W-1:0]   fpu_a;
  logic [W-1:0]   fpu_b;
  logic           fpu_op;
  logic [W-1:0]   fpu_result;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           busy;

  always #5 clk = ~clk;

  fpu_addsub_arbiter #(
    .N_REQ(N), .SIZE_DATA(W), .LATENCY(L)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req_valid(req_valid),
    .i_req_a(req_a),
    .i_req_b(req_b),
    .i_req_op(req_op),
    .o_req_ready(req_ready),
    .o_fpu_valid(fpu_valid),
    .o_fpu_a(fpu_a),
    .o_fpu_b(fpu_b),
    .o_fpu_op(fpu_op),
    .i_fpu_result(fpu_result),
    .o_rsp_valid(rsp_valid),
    .o_rsp_data(rsp_data),
    .o_busy(busy)
  );

  function automatic real s2r(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fn(
    input logic [31:0] a, input logic [31:0] b, input logic op
  );
    return r2s(op ? s2r(a) - s2r(b) : s2r(a) + s2r(b));
  endfunction

  // FPU model: fixed L-cycle pipeline of the arithmetic result.
  logic [W-1:0] fpipe [L];
  always @(posedge clk) begin
    fpipe[0] <= fn(fpu_a, fpu_b, fpu_op);
    for (int j = 1; j < L; j++) fpipe[j] <= fpipe[j-1];
  end
  assign fpu_result = fpipe[L-1];

  logic [W-1:0] ra [N];
  logic [W-1:0] rb [N];
  logic         rop [N];

  always_comb begin
    req_a  = '0;
    req_b  = '0;
    req_op = '0;
    for (int k = 0; k < N; k++) begin
      req_a[k*W +: W] = ra[k];
      req_b[k*W +: W] = rb[k];
      req_op[k]       = rop[k];
    end
  end

  typedef struct {
    int          tag;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          mptr = 0;
  int          g_last;
  bit          mon_en = 1'b0;
  bit          hs_at  [MAXC];
  bit          rst_at [MAXC];
  logic [31:0] iss_a  [MAXC];
  logic [31:0] iss_b  [MAXC];
  logic        iss_op [MAXC];
  logic [N-1:0] pend;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string name, input logic [63:0] act, input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rnd_f();
    return r2s(real'($urandom_range(1, 4096)));
  endfunction

  task automatic set_rand(input int k);
    ra[k]  = rnd_f();
    rb[k]  = rnd_f();
    rop[k] = 1'($urandom_range(0, 1));
  endtask

  // One clock cycle: inputs already driven; checks grant at the negedge.
  task automatic step(input bit do_rst, input int exp_g);
    int          g;
    logic [63:0] exp_rdy;
    exp_t        e;
    rst = do_rst;
    @(negedge clk);
    g = do_rst ? -1 : pick(req_valid, mptr);
    exp_rdy = (g < 0) ? 64'd0 : (64'd1 << g);
    chk("ready", req_ready, exp_rdy);
    if (exp_g != -2) begin
      chk("dir_grant", req_ready,
          (exp_g < 0) ? 64'd0 : (64'd1 << exp_g));
    end
    rst_at[cyc] = do_rst;
    if (do_rst) begin
      mptr = 0;
      sbq.delete();
    end else if (g >= 0) begin
      hs_at[cyc]  = 1'b1;
      iss_a[cyc]  = ra[g];
      iss_b[cyc]  = rb[g];
      iss_op[cyc] = rop[g];
      e.tag  = g;
      e.data = fn(ra[g], rb[g], rop[g]);
      e.cyc  = cyc + L + 2;
      sbq.push_back(e);
      mptr = (g + 1) % N;
    end
    g_last = g;
    @(posedge clk);
    #1;
  endtask

  // Monitor: issue bus, busy and responses against recorded history.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        bit   exp_fv;
        bit   exp_busy;
        exp_t e;
        exp_fv = (cyc > 0) && hs_at[cyc-1];
        chk("fpu_valid", fpu_valid, exp_fv);
        if (exp_fv) begin
          chk("fpu_a", fpu_a, iss_a[cyc-1]);
          chk("fpu_b", fpu_b, iss_b[cyc-1]);
          chk("fpu_op", fpu_op, iss_op[cyc-1]);
        end
        exp_busy = 1'b0;
        for (int j = 1; j <= L + 1; j++) begin
          int  h;
          bit  killed;
          h = cyc - j;
          if (h >= 0 && hs_at[h]) begin
            killed = 1'b0;
            for (int r = h; r < cyc; r++) begin
              if (rst_at[r]) killed = 1'b1;
            end
            if (!killed) exp_busy = 1'b1;
          end
        end
        chk("busy", busy, exp_busy);
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
          e = sbq.pop_front();
          checks++;
          failures++;
          $display("FAIL rsp_missing: tag %0d due cycle %0d not seen",
                   e.tag, e.cyc);
        end
        if (rsp_valid != '0) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got %0h expected none",
                     rsp_valid);
          end else begin
            e = sbq.pop_front();
            chk("rsp_valid", rsp_valid, 64'd1 << e.tag);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int exp_seq [3];
    rst       = 1'b1;
    req_valid = '0;
    pend      = '0;
    for (int k = 0; k < N; k++) begin
      ra[k] = '0; rb[k] = '0; rop[k] = 1'b0;
    end
    repeat (3) step(1'b1, -1);
    mon_en = 1'b1;

    // idle
    repeat (10) step(1'b0, -1);

    // single op from requester 2
    ra[2] = 32'h3F800000; rb[2] = 32'h40000000; rop[2] = 1'b0;
    req_valid = 4'b0100;
    step(1'b0, 2);
    req_valid = '0;
    repeat (6) step(1'b0, -1);
    chk("single_data", rsp_data, 32'h40400000);

    // wrap/skip from ptr=3 with requesters 1 and 3
    exp_seq = '{3, 1, 3};
    set_rand(1);
    set_rand(3);
    req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, exp_seq[i]);
      set_rand(g_last);
    end
    req_valid = '0;
    repeat (6) step(1'b0, -1);

    // subtraction from requester 0
    ra[0] = 32'h40A00000; rb[0] = 32'h40000000; rop[0] = 1'b1;
    req_valid = 4'b0001;
    step(1'b0, 0);
    req_valid = '0;
    chk("sub_op", fpu_op, 1'b1);
    repeat (6) step(1'b0, -1);
    chk("sub_data", rsp_data, 32'h40400000);

    // fairness from reset
    step(1'b1, -1);
    for (int k = 0; k < N; k++) set_rand(k);
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, i % 4);
      set_rand(g_last);
    end
    req_valid = '0;
    repeat (L + 4) step(1'b0, -1);

    // reset while three ops are in flight
    req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i);
      set_rand(g_last);
    end
    req_valid = '0;
    step(1'b1, -1);
    chk("rst_fpu_valid", fpu_valid, 1'b0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_fpu_b", fpu_b, 32'd0);
    chk("rst_fpu_op", fpu_op, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 4'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_busy", busy, 1'b0);
    req_valid = 4'b1111;
    step(1'b0, 0);
    req_valid = '0;
    repeat (L + 6) step(1'b0, -1);

    // randomized traffic; requesters hold until granted
    pend = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          set_rand(k);
        end
      end
      req_valid = pend;
      step(1'b0, -2);
      if (g_last >= 0) pend[g_last] = 1'b0;
    end
    req_valid = '0;
    repeat (L + 6) step(1'b0, -1);
    chk("sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
